// File: rtl/fifo_burst_drain.sv
// Read-side drain engine for the SDRAM request FIFO.
// It pops words from the fall-through head of the FIFO and groups them into
// bursts of BURST_LEN words. When the FIFO holds fewer than BURST_LEN words
// for TIMEOUT cycles, it flushes a shorter burst instead. Each burst is
// presented on a registered valid/ready stream with first/last markers.
module fifo_burst_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_EXP   = 2,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [ADDR_EXP:0]     fifo_count,
  output logic                  fifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CW = ADDR_EXP + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(BURST_LEN + 1);

  localparam logic [CW-1:0] BURST_CNT  = CW'(BURST_LEN);
  localparam logic [RW-1:0] BURST_REM  = RW'(BURST_LEN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [RW-1:0] rem;
  logic          first_pend;
  logic          room;

  // The output register can take a new word when it is empty or is being emptied now.
  assign room = !m_valid || m_ready;

  // NOTE: fifo_pop is a continuous assign, not a registered output, because the FIFO
  // has to advance at the same edge that captures its head word. It is gated by rst
  // so that the FIFO and this block reset together without losing a word.
  assign fifo_pop = !rst && (state == DRAIN) && (rem != '0) && (fifo_count != '0) && room;

  assign busy = (state != IDLE) || m_valid;

  // Burst FSM and output register, updated together on each rising edge.
  // NOTE: every assignment here is non-blocking. Each right-hand side therefore sees
  // the pre-edge value of rem, first_pend and state. The fifo_pop that loads the output
  // register also decrements rem.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      rem        <= '0;
      first_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_first    <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      if (fifo_pop) begin
        m_valid <= 1'b1;
        m_data  <= fifo_data;
        m_first <= first_pend;
        m_last  <= (rem == RW'(1));
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          timer <= '0;
          if (fifo_count >= BURST_CNT) begin
            state      <= DRAIN;
            rem        <= BURST_REM;
            first_pend <= 1'b1;
          end else if (fifo_count != '0) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          // A full burst's worth of words wins over an expiring timeout.
          if (fifo_count >= BURST_CNT) begin
            state      <= DRAIN;
            rem        <= BURST_REM;
            first_pend <= 1'b1;
            timer      <= '0;
          end else if (timer == TIMER_LAST) begin
            state      <= DRAIN;
            rem        <= RW'(fifo_count);
            first_pend <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DRAIN: begin
          if (fifo_pop) begin
            rem        <= rem - RW'(1);
            first_pend <= 1'b0;
            if (rem == RW'(1)) begin
              state <= IDLE;
            end
          end else if (rem == '0) begin
            // A burst length of zero cannot be snapshotted from a non-empty FIFO.
            // Recover anyway rather than stick in DRAIN.
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Self-checking bench for fifo_burst_drain.
// The bench owns a queue that stands in for the request FIFO. A cycle-stamp
// reference model predicts the pop strobe and the output stream. A separate
// push-order scoreboard checks every accepted word for loss, duplication and order.
module tb_fifo_burst_drain;

  localparam int DW = 8;
  localparam int AE = 2;
  localparam int BL = 4;
  localparam int TO = 16;
  localparam int DEPTH = 1 << AE;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic [AE:0]   fifo_count;
  logic          fifo_pop;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_first;
  logic          m_last;
  logic          busy;

  fifo_burst_drain #(
    .DATA_WIDTH(DW),
    .ADDR_EXP  (AE),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_count(fifo_count),
    .fifo_pop  (fifo_pop),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_first   (m_first),
    .m_last    (m_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Contents of the FIFO and the push-order scoreboard.
  logic [DW-1:0] q[$];
  logic [DW-1:0] sb[$];

  // Reference model. It records when waiting started and how many words
  // are still owed to the current burst.
  bit            known;
  bit            drn, wt;
  int            wait_since, left;
  bit            fnext;
  bit            ov, of, ol;
  logic [DW-1:0] od;

  // Per-test statistics collected from accepted beats.
  int beats, bursts, firsts, lasts, pops, cur_len, last_len, last_pop_cyc;
  int burst_lens[$];
  bit expect_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    beats = 0; bursts = 0; firsts = 0; lasts = 0; pops = 0;
    cur_len = 0; last_len = 0; last_pop_cyc = -1;
    burst_lens.delete();
  endtask

  task automatic start_burst(input int n);
    drn = 1; wt = 0; left = n; fnext = 1;
  endtask

  // One clock cycle. Inputs are applied at the falling edge and outputs are checked 1 ns later.
  // The model then advances across the rising edge.
  task automatic step(input bit push, input logic [DW-1:0] val, input bit rdy, input bit rs);
    int cnt;
    bit exp_pop;
    bit pre_drn, pre_wt;
    @(negedge clk);
    rst     = rs;
    m_ready = rdy;
    if (push && q.size() < DEPTH) begin
      q.push_back(val);
      sb.push_back(val);
    end
    fifo_count = (AE + 1)'(q.size());
    fifo_data  = (q.size() != 0) ? q[0] : '0;
    #1;
    cnt     = q.size();
    exp_pop = !rs && drn && (left > 0) && (cnt > 0) && (!ov || rdy);
    check("fifo_pop", fifo_pop, exp_pop);
    if (known) begin
      check("m_valid", m_valid, ov);
      check("m_data", m_data, od);
      check("m_first", m_first, of);
      check("m_last", m_last, ol);
      check("busy", busy, drn || wt || ov);
    end
    if (!rs && known && m_valid && m_ready) begin
      beats++;
      check("sb_data", {24'b0, m_data}, (sb.size() != 0) ? {24'b0, sb.pop_front()} : 32'hDEAD);
      check("frame_first", m_first, expect_first);
      if (m_first) begin
        firsts++;
        cur_len = 0;
      end
      cur_len++;
      expect_first = m_last;
      if (m_last) begin
        lasts++;
        last_len = cur_len;
        burst_lens.push_back(cur_len);
        bursts++;
        check("burst_len_le_max", cur_len <= BL, 1);
      end
    end
    @(posedge clk);
    if (rs) begin
      known = 1; drn = 0; wt = 0; left = 0; fnext = 0;
      ov = 0; of = 0; ol = 0; od = '0;
      expect_first = 1;
      q.delete();
      sb.delete();
    end else begin
      pre_drn = drn;
      pre_wt  = wt;
      if (exp_pop) begin
        ov = 1; od = q[0]; of = fnext; ol = (left == 1);
        left--;
        fnext = 0;
        void'(q.pop_front());
        pops++;
        last_pop_cyc = cyc;
        if (left == 0) drn = 0;
      end else if (ov && rdy) begin
        ov = 0;
      end
      if (!pre_drn && !pre_wt) begin
        if (cnt >= BL) start_burst(BL);
        else if (cnt > 0) begin
          wt = 1;
          wait_since = cyc + 1;
        end
      end else if (pre_wt) begin
        if (cnt >= BL) start_burst(BL);
        else if (cyc - wait_since == TO - 1) start_burst(cnt);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 1, 0);
  endtask

  task automatic run_until_beats(input int n, input string tag);
    for (int i = 0; i < 200 && beats < n; i++) step(0, '0, 1, 0);
    check(tag, beats, n);
  endtask

  initial begin
    int push_cyc;
    known = 0; drn = 0; wt = 0; ov = 0; of = 0; ol = 0; od = '0;
    left = 0; fnext = 0; wait_since = 0; expect_first = 1;
    rst = 1; m_ready = 1; fifo_data = '0; fifo_count = '0;
    clear_stats();

    // Reset, then one quiet cycle that checks the reset values.
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    step(0, '0, 1, 0);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);

    // Full burst: A0..A3 pushed back to back.
    clear_stats();
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 1, 0);
    idle(12);
    check("full_beats", beats, 4);
    check("full_len", last_len, 4);
    check("full_firsts", firsts, 1);
    check("full_lasts", lasts, 1);
    check("full_fifo_empty", q.size(), 0);

    // Timeout flush of a lone word.
    clear_stats();
    push_cyc = cyc;
    step(1, 8'h5A, 1, 0);
    idle(TO + 8);
    check("to_pops", pops, 1);
    check("to_len", last_len, 1);
    check("to_pop_delay", last_pop_cyc - push_cyc, TO + 1);

    // The threshold is reached in the same cycle that the timeout expires.
    clear_stats();
    for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 1, 0);
    for (int i = 0; i < 100; i++) begin
      if (wt && (cyc - wait_since == TO - 1)) break;
      step(0, '0, 1, 0);
    end
    step(1, 8'hC3, 1, 0);
    idle(12);
    check("thr_bursts", bursts, 1);
    check("thr_len", last_len, 4);

    // Backpressure after beat 2.
    clear_stats();
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 1, 0);
    run_until_beats(2, "bp_reach2");
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0);
    idle(12);
    check("bp_beats", beats, 4);
    check("bp_len", last_len, 4);

    // Reset in the middle of a burst.
    clear_stats();
    for (int i = 0; i < 4; i++) step(1, 8'h20 + 8'(i), 1, 0);
    run_until_beats(2, "mid_reach2");
    step(0, '0, 1, 1);
    step(0, '0, 1, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    clear_stats();
    for (int i = 0; i < 4; i++) step(1, 8'h30 + 8'(i), 1, 0);
    idle(12);
    check("mid_re_len", last_len, 4);
    check("mid_re_firsts", firsts, 1);

    // Timeout snapshot of three words, with a push that arrives during the drain.
    clear_stats();
    for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 1, 0);
    for (int i = 0; i < 100 && !drn; i++) step(0, '0, 1, 0);
    step(1, 8'h63, 1, 0);
    run_until_beats(3, "snap_reach3");
    check("snap_len1", last_len, 3);
    idle(TO + 10);
    check("snap_bursts", bursts, 2);
    check("snap_len2", last_len, 1);

    // Random pushes, random ready, and an occasional reset.
    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 4, DW'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 499) == 0);
    end
    idle(TO + 20);
    check("rand_sb_empty", sb.size(), 0);
    check("rand_fifo_empty", q.size(), 0);
    check("rand_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
